// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multiply/divide unit holding HI/LO with a fixed-latency busy window
//
// Ports:
//   clk        system clock, rising-edge state updates
//   reset      asynchronous active-low reset
//   md_func    EX-stage command: 0 none, 1 mthi, 2 mtlo, 3 mult, 4 div, 5-7 none
//   md_sign    1 = signed mult/div, 0 = unsigned
//   op_a       rs operand (dividend / multiplicand / mthi-mtlo source)
//   op_b       rt operand (divisor / multiplier)
//   hi, lo     architectural HI/LO (committed values only)
//   busy       mult/div in flight
//   md_hazard  busy or a mult/div being presented this cycle (combinational)

module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        md_hazard
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        shadow_hi, shadow_lo, shadow_hi_next, shadow_lo_next;
    logic [31:0]        hi_next, lo_next;
    logic               busy_next;
    logic               div_zero, div_zero_next;

    logic signed [63:0] a_ext, b_ext, b_div;
    logic [63:0]        product;
    logic [31:0]        quotient, remainder;

    // Operands widened once so signed and unsigned share the same 64-bit
    // signed datapath; zero-extended values are always non-negative.
    always_comb begin
        a_ext     = md_sign ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        b_ext     = md_sign ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        // Divide by zero never commits; a dummy divisor keeps the datapath defined.
        b_div     = (op_b == 32'd0) ? 64'sd1 : b_ext;
        product   = a_ext * b_ext;
        quotient  = 32'(a_ext / b_div);
        remainder = 32'(a_ext % b_div);
    end

    assign md_hazard = busy | (md_func == 3'd3) | (md_func == 3'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            shadow_hi <= shadow_hi_next;
            shadow_lo <= shadow_lo_next;
            div_zero  <= div_zero_next;
            hi        <= hi_next;
            lo        <= lo_next;
            busy      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        shadow_hi_next = shadow_hi;
        shadow_lo_next = shadow_lo;
        div_zero_next  = div_zero;
        hi_next        = hi;
        lo_next        = lo;
        busy_next      = busy;

        case (state)
            IDLE: begin
                case (md_func)
                    3'd1: hi_next = op_a;
                    3'd2: lo_next = op_a;
                    3'd3: begin
                        shadow_hi_next = product[63:32];
                        shadow_lo_next = product[31:0];
                        div_zero_next  = 1'b0;
                        cnt_next       = CNT_W'(MUL_CYCLES);
                        busy_next      = 1'b1;
                        state_next     = MUL;
                    end
                    3'd4: begin
                        shadow_hi_next = remainder;
                        shadow_lo_next = quotient;
                        div_zero_next  = (op_b == 32'd0);
                        cnt_next       = CNT_W'(DIV_CYCLES);
                        busy_next      = 1'b1;
                        state_next     = DIV;
                    end
                    default: ;
                endcase
            end
            // Commands arriving here are ignored; stall logic upstream must hold them.
            MUL, DIV: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (!div_zero) begin
                        hi_next = shadow_hi;
                        lo_next = shadow_lo;
                    end
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit

module tb_mul_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] op_a, op_b;
    logic [31:0] hi, lo;
    logic        busy, md_hazard;

    int checks = 0;
    int errors = 0;
    int illegal_seen = 0;
    int illegal_planned = 0;
    bit expect_illegal;

    logic [31:0] m_hi, m_lo;

    mul_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .md_func(md_func), .md_sign(md_sign),
        .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo), .busy(busy),
        .md_hazard(md_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any command presented while busy must be one the bench injected on purpose.
    always @(posedge clk) begin
        if (reset && busy && md_func >= 3'd1 && md_func <= 3'd4) begin
            illegal_seen <= illegal_seen + 1;
            assert (expect_illegal) else $error("unplanned command while busy: func=%0d", md_func);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        md_func = f;
        md_sign = s;
        op_a    = a;
        op_b    = b;
    endtask

    function automatic longint ext(input logic s, input logic [31:0] v);
        if (s) return longint'($signed(v));
        return longint'({32'd0, v});
    endfunction

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, p;
        x = ext(s, a);
        y = ext(s, b);
        p = x * y;
        return p;
    endfunction

    // Quotient from magnitudes with the sign applied afterwards (truncation
    // toward zero); remainder recovered as dividend - quotient*divisor.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, ax, ay, q, r;
        x  = ext(s, a);
        y  = ext(s, b);
        ax = (x < 0) ? -x : x;
        ay = (y < 0) ? -y : y;
        q  = ax / ay;
        if ((x < 0) != (y < 0)) q = -q;
        r  = x - q * y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                          input bit chained, input int bad_k, input logic [2:0] bad_f);
        logic [31:0] eh, el;
        logic [63:0] r;
        int n;
        eh = m_hi;
        el = m_lo;
        n  = 0;
        case (f)
            3'd1: eh = a;
            3'd2: el = a;
            3'd3: begin
                r  = ref_mul(s, a, b);
                eh = r[63:32];
                el = r[31:0];
                n  = MUL_N;
            end
            3'd4: begin
                if (b != 32'd0) begin
                    r  = ref_div(s, a, b);
                    eh = r[63:32];
                    el = r[31:0];
                end
                n = DIV_N;
            end
            default: ;
        endcase
        if (!chained) @(negedge clk);
        drive(f, s, a, b);
        #1 check("hazard_issue", 32'(md_hazard), 32'(f == 3'd3 || f == 3'd4));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check("busy_window", 32'(busy), 32'd1);
            check("hi_hold", hi, m_hi);
            check("lo_hold", lo, m_lo);
            check("hazard_busy", 32'(md_hazard), 32'd1);
            if (k == bad_k) begin
                expect_illegal = 1'b1;
                illegal_planned++;
                drive(bad_f, 1'($urandom), $urandom, $urandom);
            end else begin
                expect_illegal = 1'b0;
                drive(3'd0, 1'($urandom), $urandom, $urandom);
            end
        end
        @(negedge clk);
        expect_illegal = 1'b0;
        check("busy_done", 32'(busy), 32'd0);
        check("hi_result", hi, eh);
        check("lo_result", lo, el);
        drive(3'd0, 1'b0, $urandom, $urandom);
        m_hi = eh;
        m_lo = el;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        expect_illegal = 1'b0;
        reset = 1'b0;
        drive(3'd0, 1'b0, 32'd0, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hazard", 32'(md_hazard), 32'd0);
        reset = 1'b1;

        run_op(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 0, 3'd0);
        check("mult_s_hi", hi, 32'hFFFF_FFFF);
        check("mult_s_lo", lo, 32'hFFFF_FFF1);
        run_op(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, 3'd0);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        run_op(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 3'd0);
        check("div_s_lo", lo, 32'hFFFF_FFFD);
        check("div_s_hi", hi, 32'hFFFF_FFFF);
        run_op(3'd4, 1'b0, 32'd7, 32'd0, 1'b0, 0, 3'd0);
        check("divz_lo", lo, 32'hFFFF_FFFD);
        run_op(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 3'd0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0000_0000);
        run_op(3'd1, 1'b0, 32'h1234_5678, 32'd0, 1'b0, 0, 3'd0);
        check("mthi", hi, 32'h1234_5678);
        run_op(3'd2, 1'b0, 32'hCAFE_0001, 32'd0, 1'b0, 0, 3'd0);
        run_op(3'd3, 1'b1, 32'd1000, 32'hFFFF_FFFE, 1'b0, 2, 3'd3);
        run_op(3'd3, 1'b0, 32'd77, 32'd3, 1'b0, 3, 3'd2);
        check("mtlo_ignored", lo, 32'd231);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        drive(3'd4, 1'b1, 32'd100, 32'd7);
        repeat (3) begin
            @(negedge clk);
            drive(3'd0, 1'b0, $urandom, $urandom);
        end
        #2 reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd3, 1'b0, 32'd3, 32'd4, 1'b0, 0, 3'd0);
        check("post_rst_lo", lo, 32'd12);
        check("post_rst_hi", hi, 32'd0);

        // Back-to-back: second mult presented in the first cycle busy is low.
        run_op(3'd3, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 0, 3'd0);
        run_op(3'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 3'd0);
        check("b2b_lo", lo, 32'd1);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 1'($urandom), pick_operand(), pick_operand(),
                   bit'($urandom_range(0, 1)), 0, 3'd0);
        end

        @(negedge clk);
        check("illegal_flagged", 32'(illegal_seen), 32'(illegal_planned));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
